// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative signed multiply/divide unit.
package mdu_pkg;

  localparam int MDU_ITERS = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (shift-add) / divide (restoring) unit sharing one
// adder/subtractor; one bit per cycle on magnitudes, sign fix-up at the end.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               op_q, sa_q, sb_q, dz_q;
  logic [WIDTH:0]     mag_q;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH:0]     mag_a, mag_b, add_x;
  logic [WIDTH+1:0]   sum;
  logic               sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // WIDTH+1 bits so that the most negative operand has a representable magnitude.
  function automatic logic [WIDTH:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    return v[WIDTH-1] ? -ext : ext;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  always_comb begin
    mag_a = magnitude(a);
    mag_b = magnitude(b);
    sub   = (op_q == OP_DIV);
    // DIV compares the shifted partial remainder; MULT adds to the upper half.
    add_x = sub ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
    sum   = {1'b0, add_x} + {1'b0, (sub ? ~mag_q : mag_q)} + {{(WIDTH+1){1'b0}}, sub};
    prod_fix = (sa_q ^ sb_q) ? -acc : acc;
    quot_fix = cond_neg(acc[WIDTH-1:0], sa_q ^ sb_q);
    rem_fix  = cond_neg(acc[2*WIDTH-1:WIDTH], sa_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      dz_q  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (op == OP_DIV && b == '0) begin
              dz_q  <= 1'b1;
              state <= ST_DONE;
            end else begin
              op_q  <= op;
              sa_q  <= a[WIDTH-1];
              sb_q  <= b[WIDTH-1];
              mag_q <= (op == OP_DIV) ? mag_b : mag_a;
              acc   <= {{WIDTH{1'b0}}, ((op == OP_DIV) ? mag_a[WIDTH-1:0] : mag_b[WIDTH-1:0])};
              cnt   <= '0;
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (!sub) begin
            acc <= acc[0] ? {sum[WIDTH:0], acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
          end else if (sum[WIDTH+1]) begin
            acc <= {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          end else begin
            acc <= {acc[2*WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          if (op_q == OP_DIV) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          state <= ST_DONE;
        end
        default: begin
          dz_q  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state == ST_RUN) || (state == ST_FIX);
  assign done     = (state == ST_DONE);
  assign div_zero = done && dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against an arithmetic model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, div_zero;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result from plain signed arithmetic (truncating division).
  task automatic model(input logic opv, input logic [W-1:0] av, bv,
                       output logic [W-1:0] eh, el, output logic dz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    dz = 1'b0;
    if (opv == OP_MULT) begin
      p = sa * sb;
      eh = p[63:32];
      el = p[31:0];
    end else if (bv == '0) begin
      eh = m_hi;
      el = m_lo;
      dz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      eh = r[31:0];
      el = q[31:0];
    end
  endtask

  task automatic do_op(input logic opv, input logic [W-1:0] av, bv, input string tag);
    int n;
    logic b1, dz;
    logic [W-1:0] eh, el;
    model(opv, av, bv, eh, el, dz);
    @(negedge clk);
    start = 1'b1; op = opv; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
    n = 1;
    b1 = busy;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 64'(n), dz ? 64'd1 : 64'(W + 2));
    chk({tag, " busy_first"}, 64'(b1), 64'(!dz));
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, " div_zero"}, 64'(div_zero), 64'(dz));
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
    @(negedge clk);
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    int n;
    logic seen;
    logic [W-1:0] eh, el, ra, rb;
    logic dz;

    reset = 1'b1; start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset div_zero", 64'(div_zero), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset state", 64'(dut.state), 64'(ST_IDLE));
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("post reset busy", 64'(busy), 64'd0);

    do_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, "mul 7x-3");
    chk("mul 7x-3 hi const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    chk("mul 7x-3 lo const", 64'(lo), 64'h0000_0000_FFFF_FFEB);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div -7/2");
    chk("div -7/2 lo const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    chk("div -7/2 hi const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, "div 7/-2");
    chk("div 7/-2 hi const", 64'(hi), 64'h0000_0000_0000_0001);
    do_op(OP_DIV, 32'd5, 32'd0, "div 5/0");
    chk("div 5/0 hi kept", 64'(hi), 64'h0000_0000_0000_0001);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
    chk("div min/-1 lo const", 64'(lo), 64'h0000_0000_8000_0000);
    do_op(OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF, "mul min*-1");
    chk("mul min*-1 hi const", 64'(hi), 64'd0);
    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, "mul min*min");
    do_op(OP_DIV, 32'h8000_0000, 32'd1, "div min/1");

    // Start re-asserted with other operands during RUN must be ignored.
    model(OP_MULT, 32'd12345, 32'hFFFF_FD5A, eh, el, dz);
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd12345; b = 32'hFFFF_FD5A;
    @(negedge clk);
    n = 1;
    while (!done && n < 200) begin
      if (n == 5) begin
        start = 1'b1; op = OP_DIV; a = 32'd99; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("ignore latency", 64'(n), 64'(W + 2));
    chk("ignore hi", 64'(hi), 64'(eh));
    chk("ignore lo", 64'(lo), 64'(el));
    m_hi = eh; m_lo = el;
    repeat (3) @(negedge clk);
    chk("ignore not queued", 64'(busy), 64'd0);

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd1000; b = 32'd2000;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("midrun busy before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrun state", 64'(dut.state), 64'(ST_IDLE));
    chk("midrun hi", 64'(hi), 64'd0);
    chk("midrun lo", 64'(lo), 64'd0);
    chk("midrun busy", 64'(busy), 64'd0);
    m_hi = '0; m_lo = '0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("midrun no done", 64'(seen), 64'd0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'($signed(8'($urandom)));
        2: rb = (i % 3 == 0) ? 32'd0 : rb;
        default: ;
      endcase
      do_op(1'(i % 2), ra, rb, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
